// File: rtl/sap_pkg.sv
// Shared opcodes, sequencer state encoding and control-word layout for the
// 8-bit bus/accumulator/ALU datapath sequencer.
package sap_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LDA  = 3'b001;
   localparam logic [2:0] OP_LDB  = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_ADDI = 3'b101;
   localparam logic [2:0] OP_SUBI = 3'b110;
   localparam logic [2:0] OP_HLT  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_EXN   = 3'd1,
      S_LDI_A = 3'd2,
      S_LDI_B = 3'd3,
      S_WAIT  = 3'd4,
      S_ALU   = 3'd5,
      S_HALT  = 3'd6
   } state_t;

   // Load strobes are active low; everything else is active high.
   typedef struct packed {
      logic imm_oe;
      logic ea;
      logic eb;
      logic eu;
      logic sub;
      logic nla;
      logic nlb;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{imm_oe: 1'b0, ea: 1'b0, eb: 1'b0, eu: 1'b0,
                                   sub: 1'b0, nla: 1'b1, nlb: 1'b1};

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational map from sequencer state and latched opcode to the datapath
// control word. Only one bus driver and at most one load strobe per state.
module sap_ctrl_decode
   import sap_pkg::*;
(
   input  state_t     state,
   input  logic [2:0] op,
   output ctrl_t      ctrl
);

   logic is_sub;

   // SUB and SUBI keep the subtract select high from the first settle cycle on.
   assign is_sub = (op == OP_SUB) || (op == OP_SUBI);

   // Decode the control word; idle values first so every state is covered.
   always_comb begin
      ctrl = CTRL_IDLE;
      case (state)
         S_LDI_A: begin
            ctrl.imm_oe = 1'b1;
            ctrl.nla    = 1'b0;
         end
         S_LDI_B: begin
            ctrl.imm_oe = 1'b1;
            ctrl.nlb    = 1'b0;
         end
         S_WAIT: begin
            ctrl.sub = is_sub;
         end
         S_ALU: begin
            ctrl.eu  = 1'b1;
            ctrl.sub = is_sub;
            ctrl.nla = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sap_sequencer.sv
// Instruction sequencer for the bus/accumulator/ALU datapath. Accepts one
// instruction per valid/ready handshake, steps through its micro-steps with
// Moore-decoded strobes, captures ALU flags and pulses done on completion.
module sap_sequencer
   import sap_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int ALU_WAIT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [2:0]       instr_op,
   input  logic [WIDTH-1:0] instr_imm,
   output logic             imm_oe,
   output logic [WIDTH-1:0] imm_out,
   output logic             nLa,
   output logic             nLb,
   output logic             Ea,
   output logic             Eb,
   output logic             Eu,
   output logic             sub,
   input  logic             cf,
   input  logic             zf,
   output logic             cf_q,
   output logic             zf_q,
   output logic             done,
   output logic             halted
);

   // ALU_WAIT of 0 bypasses the settle state entirely.
   localparam logic [1:0] WAIT_LOAD = (ALU_WAIT > 0) ? 2'(ALU_WAIT - 1) : 2'd0;
   localparam state_t     ALU_ENTRY = (ALU_WAIT == 0) ? S_ALU : S_WAIT;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] op_q;
   logic [1:0] wait_cnt;
   logic       xfer;
   logic       op_is_imm_alu;
   ctrl_t      ctrl;

   assign instr_ready   = (state == S_IDLE);
   assign xfer          = instr_valid && instr_ready;
   assign halted        = (state == S_HALT);
   assign op_is_imm_alu = (op_q == OP_ADDI) || (op_q == OP_SUBI);

   // Next-state selection: dispatch on accept, chain ADDI/SUBI into the ALU path.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (xfer) begin
               case (instr_op)
                  OP_NOP:                    state_nxt = S_EXN;
                  OP_LDA:                    state_nxt = S_LDI_A;
                  OP_LDB, OP_ADDI, OP_SUBI:  state_nxt = S_LDI_B;
                  OP_ADD, OP_SUB:            state_nxt = ALU_ENTRY;
                  OP_HLT:                    state_nxt = S_HALT;
                  default:                   state_nxt = S_IDLE;
               endcase
            end
         end
         S_LDI_B: state_nxt = op_is_imm_alu ? ALU_ENTRY : S_IDLE;
         S_WAIT:  if (wait_cnt == 2'd0) state_nxt = S_ALU;
         S_EXN, S_LDI_A, S_ALU: state_nxt = S_IDLE;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control registers: state, settle counter, immediate latch, flags, done pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         wait_cnt <= 2'd0;
         imm_out  <= '0;
         cf_q     <= 1'b0;
         zf_q     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state != S_IDLE) && (state_nxt == S_IDLE);
         if (xfer) begin
            imm_out <= instr_imm;
         end
         if ((state_nxt == S_WAIT) && (state != S_WAIT)) begin
            wait_cnt <= WAIT_LOAD;
         end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - 2'd1;
         end
         if (state == S_ALU) begin
            cf_q <= cf;
            zf_q <= zf;
         end
      end
   end

   // Opcode latch; only meaningful while an instruction is in flight.
   always_ff @(posedge clk) begin
      if (xfer) begin
         op_q <= instr_op;
      end
   end

   sap_ctrl_decode u_decode (
      .state (state),
      .op    (op_q),
      .ctrl  (ctrl)
   );

   assign imm_oe = ctrl.imm_oe;
   assign Ea     = ctrl.ea;
   assign Eb     = ctrl.eb;
   assign Eu     = ctrl.eu;
   assign sub    = ctrl.sub;
   assign nLa    = ctrl.nla;
   assign nLb    = ctrl.nlb;

endmodule

// File: tb/tb_sap_sequencer.sv
// Bench for sap_sequencer: two instances (ALU_WAIT=0 and ALU_WAIT=2), each
// driving a small A/B/ALU datapath model that feeds cf/zf back.
module tb_sap_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mon_en = 1'b0;

   logic       instr_valid [2];
   logic       instr_ready [2];
   logic [2:0] instr_op    [2];
   logic [7:0] instr_imm   [2];
   logic       imm_oe      [2];
   logic [7:0] imm_out     [2];
   logic       nla         [2];
   logic       nlb         [2];
   logic       ea          [2];
   logic       eb          [2];
   logic       eu          [2];
   logic       sub         [2];
   logic       cf          [2];
   logic       zf          [2];
   logic       cf_q        [2];
   logic       zf_q        [2];
   logic       done        [2];
   logic       halted      [2];

   logic [7:0] reg_a [2] = '{8'h00, 8'h00};
   logic [7:0] reg_b [2] = '{8'h00, 8'h00};
   logic [7:0] bus   [2];
   logic [8:0] alu   [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sap_sequencer #(.WIDTH(8), .ALU_WAIT(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]),
      .instr_op(instr_op[0]), .instr_imm(instr_imm[0]),
      .imm_oe(imm_oe[0]), .imm_out(imm_out[0]),
      .nLa(nla[0]), .nLb(nlb[0]), .Ea(ea[0]), .Eb(eb[0]), .Eu(eu[0]), .sub(sub[0]),
      .cf(cf[0]), .zf(zf[0]), .cf_q(cf_q[0]), .zf_q(zf_q[0]),
      .done(done[0]), .halted(halted[0])
   );

   sap_sequencer #(.WIDTH(8), .ALU_WAIT(2)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]),
      .instr_op(instr_op[1]), .instr_imm(instr_imm[1]),
      .imm_oe(imm_oe[1]), .imm_out(imm_out[1]),
      .nLa(nla[1]), .nLb(nlb[1]), .Ea(ea[1]), .Eb(eb[1]), .Eu(eu[1]), .sub(sub[1]),
      .cf(cf[1]), .zf(zf[1]), .cf_q(cf_q[1]), .zf_q(zf_q[1]),
      .done(done[1]), .halted(halted[1])
   );

   // Datapath model: bus mux and 9-bit ALU (bit 8 is carry/borrow).
   always_comb begin
      for (int d = 0; d < 2; d++) begin
         alu[d] = sub[d] ? ({1'b0, reg_a[d]} - {1'b0, reg_b[d]})
                         : ({1'b0, reg_a[d]} + {1'b0, reg_b[d]});
         bus[d] = 8'h00;
         if (imm_oe[d])  bus[d] = imm_out[d];
         else if (eu[d]) bus[d] = alu[d][7:0];
         cf[d] = alu[d][8];
         zf[d] = (alu[d][7:0] == 8'h00);
      end
   end

   // Datapath model registers load from the bus on active-low strobes.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (nla[d] === 1'b0) reg_a[d] <= bus[d];
         if (nlb[d] === 1'b0) reg_b[d] <= bus[d];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input int d, input logic [2:0] op, input logic [7:0] imm,
                            output int lat);
      int n;
      instr_op[d]    = op;
      instr_imm[d]   = imm;
      instr_valid[d] = 1'b1;
      n = 0;
      while (!instr_ready[d] && n < 50) begin
         step();
         n++;
      end
      step();
      instr_valid[d] = 1'b0;
      lat = 1;
      while (!done[d] && lat < 50) begin
         step();
         lat++;
      end
   endtask

   // Per-cycle invariants on both instances.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            chk("bus_exclusive", 32'($countones({imm_oe[d], ea[d], eb[d], eu[d]}) <= 1), 32'd1);
            chk("not_both_loads", 32'(nla[d] || nlb[d]), 32'd1);
            chk("ea_eb_reserved", 32'(ea[d] || eb[d]), 32'd0);
            if (instr_ready[d] || halted[d])
               chk("no_load_idle_halt", 32'(nla[d] && nlb[d]), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   typedef struct {
      int         d;
      logic [2:0] op;
      logic [7:0] imm;
      int         lat;
      logic [7:0] a;
      logic       cf;
      logic       zf;
   } vec_t;

   initial begin
      vec_t       vecs[12];
      int         lat;
      int         idx;
      int         cyc;
      int         ndone;
      int         last_done;
      int         acc[3];
      logic       take;
      logic [2:0] b2b_op[3];
      logic [7:0] b2b_imm[3];

      vecs[0]  = '{0, 3'b001, 8'h05, 2, 8'h05, 1'b0, 1'b0}; // LDA 05
      vecs[1]  = '{0, 3'b010, 8'h03, 2, 8'h05, 1'b0, 1'b0}; // LDB 03
      vecs[2]  = '{0, 3'b011, 8'h00, 2, 8'h08, 1'b0, 1'b0}; // ADD
      vecs[3]  = '{0, 3'b100, 8'h00, 2, 8'h05, 1'b0, 1'b0}; // SUB
      vecs[4]  = '{0, 3'b101, 8'hFF, 3, 8'h04, 1'b1, 1'b0}; // ADDI FF
      vecs[5]  = '{0, 3'b000, 8'h77, 2, 8'h04, 1'b1, 1'b0}; // NOP keeps flags
      vecs[6]  = '{0, 3'b110, 8'h04, 3, 8'h00, 1'b0, 1'b1}; // SUBI 04
      vecs[7]  = '{0, 3'b001, 8'h80, 2, 8'h80, 1'b0, 1'b1}; // LDA keeps flags
      vecs[8]  = '{0, 3'b101, 8'h80, 3, 8'h00, 1'b1, 1'b1}; // ADDI 80
      vecs[9]  = '{1, 3'b001, 8'h08, 2, 8'h08, 1'b0, 1'b0}; // LDA 08, wait=2
      vecs[10] = '{1, 3'b010, 8'h08, 2, 8'h08, 1'b0, 1'b0}; // LDB 08
      vecs[11] = '{1, 3'b100, 8'h00, 4, 8'h00, 1'b0, 1'b1}; // SUB, two settle cycles

      b2b_op[0] = 3'b001; b2b_imm[0] = 8'h11;
      b2b_op[1] = 3'b101; b2b_imm[1] = 8'h22;
      b2b_op[2] = 3'b000; b2b_imm[2] = 8'h00;

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         instr_valid[d] = 1'b0;
         instr_op[d]    = 3'b000;
         instr_imm[d]   = 8'h00;
      end
      step(); step(); step();
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Reset state
      chk("rst_ready", 32'(instr_ready[0]), 32'd1);
      chk("rst_nla_nlb", 32'({nla[0], nlb[0]}), 32'd3);
      chk("rst_enables", 32'({imm_oe[0], ea[0], eb[0], eu[0], sub[0]}), 32'd0);
      chk("rst_flags", 32'({cf_q[0], zf_q[0]}), 32'd0);
      chk("rst_done_halted", 32'({done[0], halted[0]}), 32'd0);
      chk("rst_imm_out", 32'(imm_out[0]), 32'd0);

      // LDA 05, cycle by cycle
      instr_op[0] = 3'b001; instr_imm[0] = 8'h05; instr_valid[0] = 1'b1;
      step();
      instr_valid[0] = 1'b0; instr_imm[0] = 8'hEE;
      chk("lda_strobes", 32'({nla[0], imm_oe[0], nlb[0]}), 32'b011);
      chk("lda_imm_out", 32'(imm_out[0]), 32'h05);
      chk("lda_busy", 32'({instr_ready[0], done[0]}), 32'd0);
      step();
      chk("lda_end_strobes", 32'({nla[0], imm_oe[0]}), 32'b10);
      chk("lda_done_ready", 32'({done[0], instr_ready[0]}), 32'b11);
      chk("lda_model_a", 32'(reg_a[0]), 32'h05);
      chk("lda_imm_hold", 32'(imm_out[0]), 32'h05);
      step();
      chk("lda_done_once", 32'(done[0]), 32'd0);

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         run_instr(vecs[i].d, vecs[i].op, vecs[i].imm, lat);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("vec%0d_a", i), 32'(reg_a[vecs[i].d]), 32'(vecs[i].a));
         chk($sformatf("vec%0d_cf", i), 32'(cf_q[vecs[i].d]), 32'(vecs[i].cf));
         chk($sformatf("vec%0d_zf", i), 32'(zf_q[vecs[i].d]), 32'(vecs[i].zf));
         step();
      end

      // SUBI 08 with A=08 on the ALU_WAIT=2 instance
      run_instr(1, 3'b001, 8'h08, lat);
      chk("subi_pre_a", 32'(reg_a[1]), 32'h08);
      step();
      instr_op[1] = 3'b110; instr_imm[1] = 8'h08; instr_valid[1] = 1'b1;
      step();
      instr_valid[1] = 1'b0;
      chk("subi_ldi_b", 32'({nlb[1], imm_oe[1], nla[1], eu[1]}), 32'b0110);
      step();
      chk("subi_wait1", 32'({sub[1], eu[1], nla[1], nlb[1], imm_oe[1]}), 32'b10110);
      step();
      chk("subi_wait2", 32'({sub[1], eu[1], done[1]}), 32'b100);
      step();
      chk("subi_alu", 32'({eu[1], sub[1], nla[1]}), 32'b110);
      step();
      chk("subi_done", 32'({done[1], instr_ready[1]}), 32'b11);
      chk("subi_model_a", 32'(reg_a[1]), 32'h00);
      chk("subi_flags", 32'({cf_q[1], zf_q[1]}), 32'b01);

      // Reset mid-ADDI
      instr_op[1] = 3'b101; instr_imm[1] = 8'h01; instr_valid[1] = 1'b1;
      step();
      instr_valid[1] = 1'b0;
      step();
      chk("abort_in_wait", 32'({sub[1], instr_ready[1]}), 32'b00);
      rst_n = 1'b0;
      step();
      chk("abort_loads", 32'({nla[1], nlb[1]}), 32'b11);
      chk("abort_enables", 32'({imm_oe[1], eu[1], sub[1], ea[1], eb[1]}), 32'd0);
      chk("abort_ready", 32'(instr_ready[1]), 32'd1);
      chk("abort_flags1", 32'({cf_q[1], zf_q[1]}), 32'd0);
      chk("abort_flags0", 32'({cf_q[0], zf_q[0]}), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("abort_idle", 32'({instr_ready[1], done[1], halted[1]}), 32'b100);
      chk("abort_imm_out", 32'(imm_out[1]), 32'd0);
      chk("abort_model_a", 32'(reg_a[1]), 32'h00);
      step();
      chk("abort_no_done", 32'(done[1]), 32'd0);

      // Back-to-back LDA, ADDI, NOP with valid held high
      idx = 0; cyc = 0; ndone = 0; last_done = -1;
      acc[0] = -1; acc[1] = -1; acc[2] = -1;
      instr_op[0] = b2b_op[0]; instr_imm[0] = b2b_imm[0]; instr_valid[0] = 1'b1;
      while (cyc < 20) begin
         take = (idx < 3) && instr_ready[0];
         if (take) acc[idx] = cyc;
         if (done[0]) begin
            ndone++;
            last_done = cyc;
            chk("b2b_ready_with_done", 32'(instr_ready[0]), 32'd1);
         end
         step();
         cyc++;
         if (take) begin
            idx++;
            if (idx < 3) begin
               instr_op[0] = b2b_op[idx]; instr_imm[0] = b2b_imm[idx];
            end else begin
               instr_valid[0] = 1'b0;
            end
         end
      end
      chk("b2b_accept0", 32'(acc[0]), 32'd0);
      chk("b2b_accept1", 32'(acc[1]), 32'd2);
      chk("b2b_accept2", 32'(acc[2]), 32'd5);
      chk("b2b_done_count", 32'(ndone), 32'd3);
      chk("b2b_last_done", 32'(last_done), 32'd7);
      chk("b2b_model_a", 32'(reg_a[0]), 32'h33);
      chk("b2b_flags", 32'({cf_q[0], zf_q[0]}), 32'b00);

      // HLT: stays halted with valid held high, no done
      instr_op[0] = 3'b111; instr_imm[0] = 8'h00; instr_valid[0] = 1'b1;
      step();
      instr_op[0] = 3'b001; instr_imm[0] = 8'h55;
      for (int i = 0; i < 20; i++) begin
         chk("hlt_halted", 32'(halted[0]), 32'd1);
         chk("hlt_ready", 32'(instr_ready[0]), 32'd0);
         chk("hlt_quiet", 32'({done[0], imm_oe[0], eu[0], nla[0], nlb[0]}), 32'b00011);
         step();
      end
      chk("hlt_model_a", 32'(reg_a[0]), 32'h33);
      instr_valid[0] = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("hlt_reset_clears", 32'({halted[0], instr_ready[0]}), 32'b01);

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
